// File: rtl/abp_sender_if.sv
// Transmit channel between the ABP sender and the link: word stream out, acks back.
interface abp_sender_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_seq;
  logic                  tx_last;
  logic                  ack_valid;
  logic                  ack_seq;

  modport master (
    output tx_valid, tx_data, tx_seq, tx_last,
    input  tx_ready, ack_valid, ack_seq
  );

  modport slave (
    input  tx_valid, tx_data, tx_seq, tx_last,
    output tx_ready, ack_valid, ack_seq
  );
endinterface

// File: rtl/abp_sender.sv
// Alternating-bit-protocol transmitter: streams a frame out of the frame buffer with a
// sequence bit, waits for a matching ack and resends the whole frame on timeout.
module abp_sender #(
  parameter int ADDRESS_WIDTH  = 6,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 7
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ADDRESS_WIDTH:0]                len,
  output logic [ADDRESS_WIDTH-1:0]              buf_addr,
  input  logic [DATA_WIDTH-1:0]                 buf_data,
  abp_sender_if.master                          tx,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  fail,
  output logic [$clog2(MAX_RETRIES+2)-1:0]      retx_count
);

  localparam int LW = ADDRESS_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK
  } state_t;

  state_t                   state_q, state_d;
  logic                     seq_q, seq_d;
  logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
  logic [LW-1:0]            len_q, len_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [RW-1:0]            retx_q, retx_d;
  logic                     done_q, done_d;
  logic                     fail_q, fail_d;
  logic                     last_word;

  // idx is zero-extended so a 2**ADDRESS_WIDTH-word frame ends cleanly at the top address
  assign last_word = ({1'b0, idx_q} == (len_q - LW'(1)));

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    len_d   = len_q;
    timer_d = timer_q;
    retx_d  = retx_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          len_d   = len;
          idx_d   = '0;
          retx_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx.tx_ready) begin
          if (last_word) begin
            timer_d = '0;
            state_d = WAIT_ACK;
          end else begin
            idx_d = idx_q + ADDRESS_WIDTH'(1);
          end
        end
      end
      WAIT_ACK: begin
        timer_d = timer_q + TW'(1);
        // A matching ack beats a timeout landing in the same cycle
        if (tx.ack_valid && (tx.ack_seq == seq_q)) begin
          seq_d   = ~seq_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          if (retx_q < RW'(MAX_RETRIES)) begin
            retx_d  = retx_q + RW'(1);
            idx_d   = '0;
            state_d = SEND;
          end else begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seq_q   <= 1'b0;
      idx_q   <= '0;
      len_q   <= '0;
      timer_q <= '0;
      retx_q  <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      retx_q  <= retx_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign buf_addr    = idx_q;
  assign tx.tx_valid = (state_q == SEND);
  assign tx.tx_data  = buf_data;
  assign tx.tx_seq   = seq_q;
  assign tx.tx_last  = (state_q == SEND) && last_word;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign fail        = fail_q;
  assign retx_count  = retx_q;

endmodule
